// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared types and width helpers for the sequential combination lock.
//   state_t        - lock FSM states
//   cnt_w()        - bits needed to index/hold values 0..n-1 (minimum 1)
//   DEF_*          - default parameter values used by the top and the interface
//   *_W, code_t    - widths and code storage type for the default configuration
package combo_lock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      OPEN,
      PROGRAM,
      LOCKOUT
   } state_t;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_DIGIT_W        = 3;
   localparam int DEF_NUM_DIGITS     = 4;
   localparam int DEF_MAX_FAIL       = 3;
   localparam int DEF_LOCKOUT_CYCLES = 16;
   localparam int DEF_RELOCK_CYCLES  = 64;

   localparam int PROGRESS_W = cnt_w(DEF_NUM_DIGITS + 1);
   localparam int FAIL_W     = cnt_w(DEF_MAX_FAIL + 1);
   localparam int TIMER_W    = cnt_w(DEF_LOCKOUT_CYCLES);

   typedef logic [DEF_DIGIT_W-1:0] code_t [DEF_NUM_DIGITS];

endpackage

// File: rtl/combo_lock_seq_if.sv
// combo_lock_seq_if: user-side bus of the combination lock.
//   digit_in/digit_valid - strobed digit entry
//   clear                - abort entry / relock / abort programming
//   prog_en              - request program mode (honoured only while open)
//   unlocked/entering/lockout - status flags
//   progress             - digits accepted in the current sequence
//   fail_cnt             - consecutive failed attempts
// master drives the requests (switch/strobe decode), slave is the lock.
interface combo_lock_seq_if
   import combo_lock_pkg::*;
#(
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int MAX_FAIL   = DEF_MAX_FAIL
) ();

   logic [DIGIT_W-1:0]                   digit_in;
   logic                                 digit_valid;
   logic                                 clear;
   logic                                 prog_en;
   logic                                 unlocked;
   logic                                 entering;
   logic                                 lockout;
   logic [cnt_w(NUM_DIGITS + 1)-1:0]     progress;
   logic [cnt_w(MAX_FAIL + 1)-1:0]       fail_cnt;

   modport master (
      output digit_in, digit_valid, clear, prog_en,
      input  unlocked, entering, lockout, progress, fail_cnt
   );

   modport slave (
      input  digit_in, digit_valid, clear, prog_en,
      output unlocked, entering, lockout, progress, fail_cnt
   );

endinterface

// File: rtl/combo_lock_timer.sv
// combo_lock_timer: loadable down-counter that stops at zero.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (wins over en)
//   en        - decrement while non-zero
//   zero      - count is zero
module combo_lock_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/combo_lock_seq.sv
// combo_lock_seq: parametrised sequential combination lock with failure
// counting, timed lockout and in-place code programming.
//   clk, rst - single clock, synchronous active-high reset
//   bus      - combo_lock_seq_if.slave (digit entry, clear, prog_en, status)
// Optional feature: define COMBO_LOCK_AUTO_RELOCK_EN to return from OPEN to
// IDLE after RELOCK_CYCLES cycles without digit_valid/prog_en activity.
module combo_lock_seq
   import combo_lock_pkg::*;
#(
   parameter int DIGIT_W        = DEF_DIGIT_W,
   parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
   parameter int MAX_FAIL       = DEF_MAX_FAIL,
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter int RELOCK_CYCLES  = DEF_RELOCK_CYCLES
) (
   input logic              clk,
   input logic              rst,
   combo_lock_seq_if.slave  bus
);

   localparam int PW = cnt_w(NUM_DIGITS + 1);
   localparam int FW = cnt_w(MAX_FAIL + 1);
   localparam int IW = cnt_w(NUM_DIGITS);
   localparam int LW = cnt_w(LOCKOUT_CYCLES);

   if (MAX_FAIL < 1 || LOCKOUT_CYCLES < 1 || RELOCK_CYCLES < 1) begin : g_param_check
      $error("combo_lock_seq: MAX_FAIL, LOCKOUT_CYCLES and RELOCK_CYCLES must be >= 1");
   end

   state_t             state;
   logic [DIGIT_W-1:0] code   [NUM_DIGITS];
   logic [DIGIT_W-1:0] shadow [NUM_DIGITS];
   logic [PW-1:0]      progress;
   logic [FW-1:0]      fail_cnt;
   logic               match;
   logic               unlocked;
   logic               entering;
   logic               lockout;

   logic [IW-1:0]      idx;
   logic               accept;
   logic               last;
   logic               match_now;
   logic               fail_last;
   logic               lock_load;
   logic               lock_zero;
   logic               relock_zero;

   // IDLE behaves as ENTRY with progress 0 and a fresh (true) match flag.
   always_comb begin
      idx       = progress[IW-1:0];
      accept    = bus.digit_valid && !bus.clear && (state == IDLE || state == ENTRY);
      last      = (int'(progress) == NUM_DIGITS - 1);
      match_now = ((state == IDLE) || match) && (bus.digit_in == code[idx]);
      fail_last = (int'(fail_cnt) + 1 >= MAX_FAIL);
      lock_load = accept && last && !match_now && fail_last;
   end

   combo_lock_timer #(.W(LW)) u_lock_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (lock_load),
      .load_val (LW'(LOCKOUT_CYCLES - 1)),
      .en       (state == LOCKOUT),
      .zero     (lock_zero)
   );

`ifdef COMBO_LOCK_AUTO_RELOCK_EN
   localparam int RW = cnt_w(RELOCK_CYCLES);
   logic relock_load;

   // Reload on every way into OPEN and on activity while OPEN; the counter
   // only runs in OPEN, so it stays frozen throughout PROGRAM.
   always_comb begin
      relock_load = (accept && last && match_now)
                 || (state == PROGRAM && (bus.clear || (bus.digit_valid && last)))
                 || (state == OPEN && !bus.clear && (bus.digit_valid || bus.prog_en));
   end

   combo_lock_timer #(.W(RW)) u_relock_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (relock_load),
      .load_val (RW'(RELOCK_CYCLES - 1)),
      .en       (state == OPEN),
      .zero     (relock_zero)
   );
`else
   assign relock_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         progress <= '0;
         fail_cnt <= '0;
         match    <= 1'b0;
         unlocked <= 1'b0;
         entering <= 1'b0;
         lockout  <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            code[i]   <= '0;
            shadow[i] <= '0;
         end
      end else begin
         case (state)
            IDLE, ENTRY: begin
               if (bus.clear && state == ENTRY) begin
                  // Abort is not a failure: fail_cnt is left alone.
                  state    <= IDLE;
                  progress <= '0;
                  entering <= 1'b0;
               end else if (accept) begin
                  match <= match_now;
                  if (last) begin
                     progress <= '0;
                     entering <= 1'b0;
                     if (match_now) begin
                        state    <= OPEN;
                        unlocked <= 1'b1;
                        fail_cnt <= '0;
                     end else if (fail_last) begin
                        state   <= LOCKOUT;
                        lockout <= 1'b1;
                     end else begin
                        state    <= IDLE;
                        fail_cnt <= fail_cnt + 1'b1;
                     end
                  end else begin
                     state    <= ENTRY;
                     entering <= 1'b1;
                     progress <= progress + 1'b1;
                  end
               end
            end
            OPEN: begin
               if (bus.clear) begin
                  state    <= IDLE;
                  unlocked <= 1'b0;
               end else if (bus.prog_en) begin
                  state    <= PROGRAM;
                  progress <= '0;
               end else if (relock_zero && !bus.digit_valid) begin
                  state    <= IDLE;
                  unlocked <= 1'b0;
               end
            end
            PROGRAM: begin
               if (bus.clear) begin
                  state    <= OPEN;
                  progress <= '0;
               end else if (bus.digit_valid) begin
                  shadow[idx] <= bus.digit_in;
                  if (last) begin
                     // The final digit bypasses the shadow so the whole code
                     // commits on the edge that samples it.
                     for (int i = 0; i < NUM_DIGITS; i++) begin
                        code[i] <= (i == int'(idx)) ? bus.digit_in : shadow[i];
                     end
                     state    <= OPEN;
                     progress <= '0;
                  end else begin
                     progress <= progress + 1'b1;
                  end
               end
            end
            LOCKOUT: begin
               if (lock_zero) begin
                  state    <= IDLE;
                  lockout  <= 1'b0;
                  fail_cnt <= '0;
               end
            end
            default: begin
               state    <= IDLE;
               progress <= '0;
               unlocked <= 1'b0;
               entering <= 1'b0;
               lockout  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.unlocked = unlocked;
   assign bus.entering = entering;
   assign bus.lockout  = lockout;
   assign bus.progress = progress;
   assign bus.fail_cnt = fail_cnt;

endmodule

// File: tb/tb_combo_lock_seq.sv
// tb_combo_lock_seq: scenario tasks plus a randomized run checked against a
// queue-based behavioural model of the lock.
module tb_combo_lock_seq;

   localparam int DIGIT_W  = 3;
   localparam int N        = 4;
   localparam int MAX_FAIL = 3;
   localparam int LOCK     = 16;
   localparam int RELOCK   = 64;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;

   combo_lock_seq_if #(.DIGIT_W(DIGIT_W), .NUM_DIGITS(N), .MAX_FAIL(MAX_FAIL)) bus ();

   combo_lock_seq #(
      .DIGIT_W        (DIGIT_W),
      .NUM_DIGITS     (N),
      .MAX_FAIL       (MAX_FAIL),
      .LOCKOUT_CYCLES (LOCK),
      .RELOCK_CYCLES  (RELOCK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: stored code, digits typed so far, mode flags, counters.
   int m_code [N];
   int m_ent [$];
   int m_prg [$];
   bit m_open;
   bit m_prog;
   int m_lock;
   int m_fail;
   int m_rel;

   function automatic void model_step(bit r, bit dv, int d, bit clr, bit pe);
      if (r) begin
         foreach (m_code[i]) m_code[i] = 0;
         m_ent.delete();
         m_prg.delete();
         m_open = 0;
         m_prog = 0;
         m_lock = 0;
         m_fail = 0;
         m_rel  = 0;
         return;
      end
      if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_fail = 0;
      end else if (m_prog) begin
         if (clr) begin
            m_prg.delete();
            m_prog = 0;
            m_open = 1;
            m_rel  = RELOCK;
         end else if (dv) begin
            m_prg.push_back(d);
            if (m_prg.size() == N) begin
               foreach (m_code[i]) m_code[i] = m_prg[i];
               m_prg.delete();
               m_prog = 0;
               m_open = 1;
               m_rel  = RELOCK;
            end
         end
      end else if (m_open) begin
         if (clr) m_open = 0;
         else if (pe) begin
            m_open = 0;
            m_prog = 1;
         end
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
         else if (dv) m_rel = RELOCK;
         else begin
            m_rel--;
            if (m_rel == 0) m_open = 0;
         end
`endif
      end else begin
         if (clr) m_ent.delete();
         else if (dv) begin
            m_ent.push_back(d);
            if (m_ent.size() == N) begin
               bit ok;
               ok = 1;
               foreach (m_code[i]) if (m_ent[i] != m_code[i]) ok = 0;
               m_ent.delete();
               if (ok) begin
                  m_open = 1;
                  m_fail = 0;
                  m_rel  = RELOCK;
               end else if (m_fail + 1 >= MAX_FAIL) m_lock = LOCK;
               else m_fail++;
            end
         end
      end
   endfunction

   task automatic cyc(input bit r, input bit dv, input int d, input bit clr, input bit pe);
      rst             = r;
      bus.digit_valid = dv;
      bus.digit_in    = DIGIT_W'(d);
      bus.clear       = clr;
      bus.prog_en     = pe;
      @(posedge clk);
      model_step(r, dv, d & 7, clr, pe);
      #1;
      rst             = 1'b0;
      bus.digit_valid = 1'b0;
      bus.clear       = 1'b0;
      bus.prog_en     = 1'b0;
   endtask

   task automatic enter(input int a, input int b, input int c, input int e);
      cyc(0, 1, a, 0, 0);
      cyc(0, 1, b, 0, 0);
      cyc(0, 1, c, 0, 0);
      cyc(0, 1, e, 0, 0);
   endtask

   task automatic test_reset;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 3, 1, 1);
      n_run += 5;
      if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked got %b want 0", bus.unlocked); end
      if (bus.entering !== 1'b0) begin n_fail++; $display("FAIL reset_entering got %b want 0", bus.entering); end
      if (bus.lockout !== 1'b0) begin n_fail++; $display("FAIL reset_lockout got %b want 0", bus.lockout); end
      if (bus.progress !== 3'd0) begin n_fail++; $display("FAIL reset_progress got %0d want 0", bus.progress); end
      if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_fail_cnt got %0d want 0", bus.fail_cnt); end
   endtask

   task automatic test_default_open;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      n_run += 3;
      if (bus.entering !== 1'b1) begin n_fail++; $display("FAIL entry_entering got %b want 1", bus.entering); end
      if (bus.progress !== 3'd3) begin n_fail++; $display("FAIL entry_progress got %0d want 3", bus.progress); end
      if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL entry_early_unlock got %b want 0", bus.unlocked); end
      cyc(0, 1, 0, 0, 0);
      n_run += 4;
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL default_open got %b want 1", bus.unlocked); end
      if (bus.entering !== 1'b0) begin n_fail++; $display("FAIL open_entering got %b want 0", bus.entering); end
      if (bus.progress !== 3'd0) begin n_fail++; $display("FAIL open_progress got %0d want 0", bus.progress); end
      if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL open_fail_cnt got %0d want 0", bus.fail_cnt); end
   endtask

   task automatic test_program;
      cyc(0, 1, 6, 0, 1);
      cyc(0, 1, 5, 0, 0);
      cyc(0, 1, 2, 0, 0);
      cyc(0, 1, 7, 0, 0);
      n_run += 2;
      if (bus.progress !== 3'd3) begin n_fail++; $display("FAIL prog_progress got %0d want 3", bus.progress); end
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_unlocked got %b want 1", bus.unlocked); end
      cyc(0, 1, 1, 0, 0);
      n_run += 2;
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_done_open got %b want 1", bus.unlocked); end
      if (bus.progress !== 3'd0) begin n_fail++; $display("FAIL prog_done_progress got %0d want 0", bus.progress); end
      cyc(0, 0, 0, 1, 0);
      n_run += 1;
      if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL relock_clear got %b want 0", bus.unlocked); end
      enter(5, 2, 7, 1);
      n_run += 1;
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL new_code_open got %b want 1", bus.unlocked); end
      cyc(0, 0, 0, 1, 0);
      enter(5, 2, 7, 0);
      n_run += 2;
      if (bus.unlocked !== 1'b0) begin n_fail++; $display("FAIL wrong_code_open got %b want 0", bus.unlocked); end
      if (bus.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL wrong_code_fail_cnt got %0d want 1", bus.fail_cnt); end
   endtask

   task automatic test_lockout;
      int cnt;
      enter(5, 2, 7, 1);
      cyc(0, 0, 0, 1, 0);
      enter(1, 1, 1, 1);
      enter(0, 0, 0, 0);
      n_run += 1;
      if (bus.fail_cnt !== 2'd2) begin n_fail++; $display("FAIL lock_pre_fail_cnt got %0d want 2", bus.fail_cnt); end
      enter(5, 2, 7, 2);
      cnt = 0;
      for (int i = 0; i < 100 && bus.lockout === 1'b1; i++) begin
         cnt++;
         cyc(0, $urandom_range(0, 1), 5 + (i % 2), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      n_run += 4;
      if (cnt != LOCK) begin n_fail++; $display("FAIL lockout_len got %0d want %0d", cnt, LOCK); end
      if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL post_lock_fail_cnt got %0d want 0", bus.fail_cnt); end
      if (bus.entering !== 1'b0) begin n_fail++; $display("FAIL post_lock_entering got %b want 0", bus.entering); end
      enter(5, 2, 7, 1);
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL post_lock_open got %b want 1", bus.unlocked); end
      cyc(0, 0, 0, 1, 0);
   endtask

   task automatic test_abort;
      enter(0, 0, 0, 0);
      cyc(0, 1, 5, 0, 0);
      cyc(0, 1, 2, 0, 0);
      n_run += 1;
      if (bus.progress !== 3'd2) begin n_fail++; $display("FAIL abort_pre_progress got %0d want 2", bus.progress); end
      cyc(0, 0, 0, 1, 0);
      n_run += 3;
      if (bus.progress !== 3'd0) begin n_fail++; $display("FAIL abort_progress got %0d want 0", bus.progress); end
      if (bus.entering !== 1'b0) begin n_fail++; $display("FAIL abort_entering got %b want 0", bus.entering); end
      if (bus.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL abort_fail_cnt got %0d want 1", bus.fail_cnt); end
      cyc(0, 1, 5, 1, 0);
      n_run += 2;
      if (bus.progress !== 3'd0) begin n_fail++; $display("FAIL clear_vs_digit got %0d want 0", bus.progress); end
      if (bus.entering !== 1'b0) begin n_fail++; $display("FAIL clear_vs_digit_ent got %b want 0", bus.entering); end
   endtask

   task automatic test_prog_abort;
      enter(5, 2, 7, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 3, 0, 0);
      cyc(0, 1, 3, 0, 0);
      cyc(0, 1, 3, 0, 0);
      cyc(0, 0, 0, 1, 0);
      n_run += 2;
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_abort_open got %b want 1", bus.unlocked); end
      if (bus.progress !== 3'd0) begin n_fail++; $display("FAIL prog_abort_progress got %0d want 0", bus.progress); end
      cyc(0, 0, 0, 1, 0);
      enter(5, 2, 7, 1);
      n_run += 1;
      if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL old_code_kept got %b want 1", bus.unlocked); end
      cyc(0, 0, 0, 1, 0);
   endtask

`ifdef COMBO_LOCK_AUTO_RELOCK_EN
   task automatic test_relock;
      int cnt;
      cyc(1, 0, 0, 0, 0);
      enter(0, 0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 200 && bus.unlocked === 1'b1; i++) begin
         cnt++;
         cyc(0, 0, 0, 0, 0);
      end
      n_run += 1;
      if (cnt != RELOCK) begin n_fail++; $display("FAIL relock_len got %0d want %0d", cnt, RELOCK); end
      enter(0, 0, 0, 0);
      for (int i = 1; i < 60; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 4, 0, 0);
      cnt = 0;
      for (int i = 0; i < 200 && bus.unlocked === 1'b1; i++) begin
         cnt++;
         cyc(0, 0, 0, 0, 0);
      end
      n_run += 1;
      if (cnt != RELOCK) begin n_fail++; $display("FAIL relock_extend got %0d want %0d", cnt, RELOCK); end
   endtask
`endif

   task automatic test_random;
      logic       ex_u, ex_e, ex_l;
      logic [2:0] ex_p;
      logic [1:0] ex_f;
      int         d;
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if (!m_prog && m_ent.size() < N && $urandom_range(0, 3) != 0) d = m_code[m_ent.size()];
         else d = $urandom_range(0, 7);
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0, d,
             $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0);
         ex_u = m_open || m_prog;
         ex_e = (m_ent.size() > 0);
         ex_l = (m_lock > 0);
         ex_p = 3'(m_prog ? m_prg.size() : m_ent.size());
         ex_f = 2'(m_fail);
         n_run += 5;
         if (bus.unlocked !== ex_u) begin n_fail++; $display("FAIL rnd_unlocked cyc %0d got %b want %b", i, bus.unlocked, ex_u); end
         if (bus.entering !== ex_e) begin n_fail++; $display("FAIL rnd_entering cyc %0d got %b want %b", i, bus.entering, ex_e); end
         if (bus.lockout !== ex_l) begin n_fail++; $display("FAIL rnd_lockout cyc %0d got %b want %b", i, bus.lockout, ex_l); end
         if (bus.progress !== ex_p) begin n_fail++; $display("FAIL rnd_progress cyc %0d got %0d want %0d", i, bus.progress, ex_p); end
         if (bus.fail_cnt !== ex_f) begin n_fail++; $display("FAIL rnd_fail_cnt cyc %0d got %0d want %0d", i, bus.fail_cnt, ex_f); end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      n_run           = 0;
      n_fail          = 0;
      rst             = 1'b1;
      bus.digit_in    = '0;
      bus.digit_valid = 1'b0;
      bus.clear       = 1'b0;
      bus.prog_en     = 1'b0;
      test_reset();
      test_default_open();
      test_program();
      test_lockout();
      test_abort();
      test_prog_abort();
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
      test_relock();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
